hazard_detection_unit: RTL and testbench
========================================

// Module: hazard_detection_unit
// PURPOSE
// Load-use hazard detector and pipeline stall/flush sequencer for the 5-stage MIPS pipeline.
// Produces lw_hazard, which the control unit consumes to zero its control outputs (bubble),
// and also drives PC / IF-ID write enables and the flushes for branches taken in MEM.
// Tracks the load currently in EX with its own shadow register. Counts stall cycles.
// PARAMETERS
// STALL_CYCLES  1   bubbles inserted per load-use hazard (>=1; >1 for slow data memory)
// CNT_W         16  width of stall_count performance counter
// PORTS
// clk          in   1      pipeline clock, rising edge
// rst          in   1      asynchronous reset, active-high
// id_valid     in   1      ID stage holds a real instruction
// id_opcode    in   6      opcode of instruction in ID
// id_rs        in   5      rs field of instruction in ID
// id_rt        in   5      rt field of instruction in ID
// br_taken     in   1      BEQ resolved taken in MEM this cycle
// lw_hazard    out  1      to control unit: force bubble into ID/EX
// pc_write     out  1      PC update enable
// ifid_write   out  1      IF/ID register write enable
// ifid_flush   out  1      clear IF/ID
// idex_flush   out  1      clear ID/EX
// exmem_flush  out  1      clear EX/MEM
// stall_count  out  CNT_W  cycles with lw_hazard=1, saturating
// BEHAVIOUR
// - Opcodes: R_TYPE 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100.
// - Source use: R_TYPE/SW/BEQ read rs and rt; LW/ADDI/unknown read rs only.
// - Shadow (ex_ld_v, ex_ld_rt): each non-stall, non-flush edge captures
//   id_valid && id_opcode==LW, and id_rt; a stall or flush edge loads ex_ld_v=0.
// - hit = ex_ld_v && ex_ld_rt!=0 && id_valid && (id_rs==ex_ld_rt || (uses_rt && id_rt==ex_ld_rt)).
// - FSM states IDLE, STALL; counter cnt (width clog2(STALL_CYCLES)+1).
// - IDLE: hit & !br_taken -> stall this cycle (Mealy, same cycle as hit). If STALL_CYCLES>1,
//   go to STALL with cnt=STALL_CYCLES-1, else stay IDLE.
// - STALL: stall every cycle; cnt decrements; cnt==1 -> IDLE on that edge. hit is not re-evaluated.
// - Stall cycle outputs: lw_hazard=1, pc_write=0, ifid_write=0, flushes=0.
// - No-stall outputs: lw_hazard=0, pc_write=1, ifid_write=1.
// - br_taken has priority over everything, in any state: ifid_flush=idex_flush=exmem_flush=1,
//   lw_hazard=0, pc_write=1, ifid_write=1. Next state IDLE, cnt=0, ex_ld_v=0.
// - stall_count increments on every edge where lw_hazard=1; holds at 2^CNT_W-1.
// - Reset (async, any time incl. mid-STALL): state IDLE, cnt 0, ex_ld_v 0, ex_ld_rt 0,
//   stall_count 0. While rst=1, outputs are forced: lw_hazard 0, pc_write 1,
//   ifid_write 1, all flushes 0.
// - Back-to-back loads: LW then dependent LW stalls once; the second LW is then tracked normally.
// TESTING
// 1. LW rt=9 in ID, then ADD rs=9 in ID -> lw_hazard=1, pc_write=0, ifid_write=0 for 1 cycle;
//    ADD is held in ID; the next cycle shows lw_hazard=0; stall_count=1.
// 2. LW rt=0, then ADD rs=0 rt=0 -> no stall (lw_hazard stays 0).
// 3. LW rt=9, then ADDI rs=3 rt=9 -> no stall; LW rt=9, then SW rs=4 rt=9 -> 1-cycle stall.
// 4. STALL_CYCLES=3, LW rt=5, then BEQ rt=5 -> lw_hazard=1 for exactly 3 cycles; stall_count=3.
// 5. br_taken=1 in the same cycle as a hit -> all flushes=1, lw_hazard=0, pc_write=1;
//    next cycle: no stall, ex_ld_v=0.
// 6. STALL_CYCLES=3, assert rst in the 2nd stall cycle -> outputs take reset values immediately;
//    after release: IDLE, stall_count=0.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Purpose: load-use hazard detector and stall/flush sequencer for a 5-stage MIPS pipeline.
// Latency: outputs are combinational from the ID-stage fields (same-cycle stall); state updates on clk.
// Backpressure: a stall drops pc_write/ifid_write and bubbles ID/EX; a taken branch overrides any stall.
//
// Ports:
//   clk, rst                      pipeline clock (rising edge), asynchronous active-high reset
//   id_valid/id_opcode/id_rs/id_rt  instruction currently in ID
//   br_taken                      BEQ resolved taken in MEM this cycle
//   lw_hazard                     to control unit: force a bubble into ID/EX
//   pc_write, ifid_write          PC / IF-ID write enables (low while stalling)
//   ifid_flush, idex_flush, exmem_flush   pipeline register clears for a taken branch
//   stall_count                   saturating count of cycles with lw_hazard=1
module hazard_detection_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             br_taken,
    output logic             lw_hazard,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_count
);

    localparam int CW = $clog2(STALL_CYCLES) + 1;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;

    typedef enum logic {IDLE, STALL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ex_ld_v;
    logic [4:0]    ex_ld_rt;
    logic          uses_rt;
    logic          hit;
    logic          stall;

    // Only R-type, SW and BEQ read rt as a source; every other opcode reads rs alone.
    assign uses_rt = (id_opcode == OP_R_TYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);

    // A load into $zero never produces a real dependency.
    assign hit = ex_ld_v && (ex_ld_rt != 5'd0) && id_valid &&
                 ((id_rs == ex_ld_rt) || (uses_rt && (id_rt == ex_ld_rt)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        if (br_taken) begin
            // The branch squashes whatever is in ID, so any pending stall is abandoned.
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        stall = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CW'(STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    // The dependent instruction is frozen in ID, so hit is not re-checked here.
                    stall   = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are held at their safe values for as long as reset is asserted.
    always_comb begin
        lw_hazard   = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst) begin
            if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (stall) begin
                lw_hazard  = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shadow of the instruction moving into EX. A bubble or flush means nothing valid enters EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ld_v  <= 1'b0;
            ex_ld_rt <= 5'd0;
        end else if (br_taken || stall) begin
            ex_ld_v  <= 1'b0;
        end else begin
            ex_ld_v  <= id_valid && (id_opcode == OP_LW);
            ex_ld_rt <= id_rt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (lw_hazard && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;

    // {lw_hazard, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
    localparam logic [5:0] NSO = 6'b011000;
    localparam logic [5:0] STO = 6'b100000;
    localparam logic [5:0] FLO = 6'b011111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = 6'd0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       br_taken = 1'b0;

    logic        lw1, pc1, if1, iff1, idf1, exf1;
    logic [15:0] sc1;
    logic        lw3, pc3, if3, iff3, idf3, exf3;
    logic [3:0]  sc3;

    int vectors = 0;
    int miscompares = 0;

    // Model state per configuration: 0 = (1 bubble, 16-bit counter), 1 = (3 bubbles, 4-bit counter)
    int m_n[2]   = '{1, 3};
    int m_max[2] = '{65535, 15};
    int m_rem[2];
    bit m_v[2];
    int m_rt[2];
    int m_sc[2];

    always #5 clk = ~clk;

    hazard_detection_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .br_taken(br_taken),
        .lw_hazard(lw1), .pc_write(pc1), .ifid_write(if1), .ifid_flush(iff1),
        .idex_flush(idf1), .exmem_flush(exf1), .stall_count(sc1)
    );

    hazard_detection_unit #(.STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .br_taken(br_taken),
        .lw_hazard(lw3), .pc_write(pc3), .ifid_write(if3), .ifid_flush(iff3),
        .idex_flush(idf3), .exmem_flush(exf3), .stall_count(sc3)
    );

    wire [5:0] o1 = {lw1, pc1, if1, iff1, idf1, exf1};
    wire [5:0] o3 = {lw3, pc3, if3, iff3, idf3, exf3};

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    function automatic bit reads_rt(input logic [5:0] op);
        return (op == R) || (op == SW) || (op == BQ);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_v[k] = 0; m_rt[k] = 0; m_sc[k] = 0;
        end
    endtask

    // Compare both DUTs with the model for the current inputs, then advance the model over one edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit hit, stl;
            logic [5:0] exp_o;
            int act_o, act_sc;
            hit = m_v[k] && (m_rt[k] != 0) && id_valid &&
                  ((int'(id_rs) == m_rt[k]) || (reads_rt(id_opcode) && int'(id_rt) == m_rt[k]));
            stl = !br_taken && (m_rem[k] > 0 || hit);
            exp_o = br_taken ? FLO : (stl ? STO : NSO);
            act_o  = (k == 0) ? int'(o1) : int'(o3);
            act_sc = (k == 0) ? int'(sc1) : int'(sc3);
            chk(k == 0 ? "model_out_n1" : "model_out_n3", act_o, int'(exp_o));
            chk(k == 0 ? "model_sc_n1" : "model_sc_n3", act_sc, m_sc[k]);
            if (br_taken) begin
                m_rem[k] = 0;
                m_v[k]   = 0;
            end else if (stl) begin
                m_v[k]   = 0;
                m_rem[k] = (m_rem[k] > 0) ? m_rem[k] - 1 : m_n[k] - 1;
            end else begin
                m_v[k]  = id_valid && (id_opcode == LW);
                m_rt[k] = int'(id_rt);
            end
            if (stl && m_sc[k] < m_max[k]) m_sc[k]++;
        end
    endtask

    task automatic set_in(input logic v, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; br_taken = br;
    endtask

    task automatic finish_cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br);
        set_in(v, op, rs, rt, br);
        @(negedge clk);
        finish_cyc();
    endtask

    task automatic do_reset();
        set_in(1'b0, R, 5'd0, 5'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_out_n1", int'(o1), int'(NSO));
        chk("rst_out_n3", int'(o3), int'(NSO));
        chk("rst_sc_n1", int'(sc1), 0);
        chk("rst_sc_n3", int'(sc3), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic [5:0] exp_o;
        int         exp_sc;
    } vec_t;

    vec_t tbl[$];

    logic [5:0] ops[8] = '{R, AI, LW, SW, BQ, LW, LW, 6'h0f};
    int lw_exp[4] = '{1, 1, 1, 0};

    initial begin
        // Expected values are for the single-bubble instance.
        tbl.push_back(vec_t'{1, LW, 5'd1, 5'd9, 0, NSO, 0});
        tbl.push_back(vec_t'{1, R,  5'd9, 5'd2, 0, STO, 0});
        tbl.push_back(vec_t'{1, R,  5'd9, 5'd2, 0, NSO, 1});
        tbl.push_back(vec_t'{1, LW, 5'd0, 5'd0, 0, NSO, 1});
        tbl.push_back(vec_t'{1, R,  5'd0, 5'd0, 0, NSO, 1});
        tbl.push_back(vec_t'{1, LW, 5'd1, 5'd9, 0, NSO, 1});
        tbl.push_back(vec_t'{1, AI, 5'd3, 5'd9, 0, NSO, 1});
        tbl.push_back(vec_t'{1, LW, 5'd1, 5'd9, 0, NSO, 1});
        tbl.push_back(vec_t'{1, SW, 5'd4, 5'd9, 0, STO, 1});
        tbl.push_back(vec_t'{1, SW, 5'd4, 5'd9, 0, NSO, 2});
        tbl.push_back(vec_t'{1, LW, 5'd1, 5'd9, 0, NSO, 2});
        tbl.push_back(vec_t'{1, R,  5'd9, 5'd0, 1, FLO, 2});
        tbl.push_back(vec_t'{1, R,  5'd9, 5'd0, 0, NSO, 2});
        tbl.push_back(vec_t'{1, LW, 5'd2, 5'd9, 0, NSO, 2});
        tbl.push_back(vec_t'{1, LW, 5'd9, 5'd7, 0, STO, 2});
        tbl.push_back(vec_t'{1, LW, 5'd9, 5'd7, 0, NSO, 3});
        tbl.push_back(vec_t'{1, BQ, 5'd1, 5'd7, 0, STO, 3});
        tbl.push_back(vec_t'{1, BQ, 5'd1, 5'd7, 0, NSO, 4});
        tbl.push_back(vec_t'{0, LW, 5'd1, 5'd9, 0, NSO, 4});
        tbl.push_back(vec_t'{1, R,  5'd9, 5'd0, 0, NSO, 4});
        tbl.push_back(vec_t'{1, LW, 5'd1, 5'd9, 0, NSO, 4});
        tbl.push_back(vec_t'{0, R,  5'd9, 5'd0, 0, NSO, 4});

        do_reset();
        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].br);
            @(negedge clk);
            chk("tbl_out", int'(o1), int'(tbl[i].exp_o));
            chk("tbl_sc", int'(sc1), tbl[i].exp_sc);
            finish_cyc();
        end

        // Three-bubble stall on a BEQ that reads the loaded register through rt.
        do_reset();
        cyc(1, LW, 5'd1, 5'd5, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(1, BQ, 5'd1, 5'd5, 0);
            @(negedge clk);
            chk("n3_stall_len", int'(lw3), lw_exp[i]);
            finish_cyc();
        end
        chk("n3_stall_count", int'(sc3), 3);

        // Asynchronous reset in the middle of the second bubble.
        do_reset();
        cyc(1, LW, 5'd1, 5'd5, 0);
        cyc(1, BQ, 5'd1, 5'd5, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out", int'(o3), int'(NSO));
        chk("midrst_sc", int'(sc3), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1, BQ, 5'd1, 5'd5, 0);
        @(negedge clk);
        chk("post_rst_lw", int'(lw3), 0);
        chk("post_rst_sc", int'(sc3), 0);
        finish_cyc();

        // Branch taken in the same cycle as a hit, then the dependent instruction reappears.
        do_reset();
        cyc(1, LW, 5'd1, 5'd6, 0);
        set_in(1, R, 5'd6, 5'd6, 1);
        @(negedge clk);
        chk("br_hit_out", int'(o3), int'(FLO));
        finish_cyc();
        set_in(1, R, 5'd6, 5'd6, 0);
        @(negedge clk);
        chk("br_after_lw", int'(lw3), 0);
        finish_cyc();

        // Drive the narrow counter into saturation.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, LW, 5'd1, 5'd5, 0);
            for (int j = 0; j < 3; j++) cyc(1, BQ, 5'd1, 5'd5, 0);
        end
        chk("n3_saturate", int'(sc3), 15);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(logic'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 7)],
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                logic'($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
